hls_shared_sched: RTL and testbench
===================================

# hls_shared_sched

Resource-constrained, FSM-scheduled successor to the free-running HLS test datapaths. Computes j = a+b+c+d and l = e*f*g over a parametrised data width using one shared adder and one shared multiplier. It captures operands on a Start handshake and signals completion with a one-cycle Done pulse. It sits alongside the latency-test HLSM blocks as the scheduled, bit-width-generic reference for testbench comparison.

## Interface

- DATA_W, 16, width of every operand, intermediate and result (two's complement)
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE or FINAL
- a, b, c, d, e, f, g  in  DATA_W each  signed operands, captured on accepted Start
- Busy  out  1  high in S1, S2, S3
- Done  out  1  one-cycle completion pulse (high in FINAL)
- j  out  DATA_W  signed sum result, registered
- l  out  DATA_W  signed product result, registered

## Operation

- States: IDLE, S1, S2, S3, FINAL, encoded in a state register.
- Accepting Start:
  - IDLE with Start=1: capture a..g into operand registers, go to S1.
  - IDLE with Start=0: stay in IDLE.
- Schedule (one adder, one multiplier, one op each per state):
  - S1: h <= a+b; k <= e*f; go to S2.
  - S2: i <= h+c; m <= k*g; go to S3.
  - S3: j <= i+d; l <= m; go to FINAL.
- FINAL:
  - Done=1.
  - Start=1: capture a new operand set and go to S1 (back-to-back).
  - Start=0: go to IDLE.
- Start in S1..S3 is ignored; no queuing.
- Operand changes after capture do not affect the running computation.
- Arithmetic:
  - Every add and multiply result is truncated to its low DATA_W bits (wrap-around, no saturation, no overflow flag).
  - Products keep the low DATA_W bits of the full 2*DATA_W product.
- j and l hold their last values until the next S3 update; they do not change in IDLE.
- Busy and Done are Moore outputs decoded from the state register.

## Timing

- Reset (Rst=0, asynchronous, regardless of Clk):
  - State goes to IDLE; j, l, h, i, k, m and operand registers go to 0; Busy=0; Done=0.
  - Takes effect immediately.
- Reset mid-operation aborts the computation: no Done pulse, results forced to 0.
- Release: first accepted Start is at the first rising edge with Rst=1 and Start=1.
- Latency, with Start sampled high at edge T:
  - Busy=1 from T to T+3.
  - j and l update at edge T+3.
  - Done=1 for exactly one cycle, from T+3 to T+4.
- Throughput: one result per 4 cycles when Start is held high or re-asserted in FINAL.
- In back-to-back operation Busy drops for exactly the FINAL cycle, then rises again.
- Start and Rst are both required synchronous to Clk, except Rst assertion.

## Test plan

- Basic, DATA_W=16: a=1, b=2, c=3, d=4, e=2, f=3, g=4; Start pulsed one cycle at edge T -> Busy high T..T+3; Done high only in cycle T+3..T+4; j=10, l=24.
- Signed: a=-5, b=3, c=-1, d=0, e=-2, f=7, g=3 -> j=-3, l=-42, Done 4 cycles after Start.
- Wrap-around:
  - a=32767, b=1, c=0, d=0 -> j=-32768.
  - e=256, f=256, g=2 -> e*f truncates to 0 -> l=0.
  - DATA_W=8 instance with e=16, f=16, g=1 -> l=0; a=127, b=1 -> j=-128.
- Ignored Start and operand isolation:
  - Start re-pulsed in S2 and operands changed during S1..S3 -> exactly one Done.
  - Results match the originally captured operands.
- Back-to-back:
  - Start held high for 12 cycles with a new operand set presented at each FINAL cycle -> Done pulses at T+3, T+7, T+11.
  - Each result matches its own operand set; Busy low only in FINAL cycles.
- Async reset:
  - Rst driven low between edges during S2 -> Busy=0, j=0, l=0 immediately, no Done.
  - After release, a new Start completes normally in 4 cycles.

Source files
------------

// File: rtl/hls_shared_sched.sv
// Purpose : j = a+b+c+d and l = e*f*g over DATA_W bits using one shared adder and one shared multiplier.
// Latency : Start accepted at edge T; results and a one-cycle Done appear at edge T+3. One result every 4 cycles.
// Backpr. : Start is sampled only in IDLE or FINAL. It is ignored while Busy, and nothing is queued.
//
// Ports:
//   Clk, Rst        rising-edge clock, asynchronous active-low reset
//   Start           request; operands a..g are captured when it is accepted
//   a..g            signed DATA_W operands
//   Busy            high while computing (S1..S3)
//   Done            high for the single FINAL cycle
//   j, l            registered sum and product results; held until the next S3
module hls_shared_sched #(
  parameter int DATA_W = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  input  logic signed [DATA_W-1:0] e,
  input  logic signed [DATA_W-1:0] f,
  input  logic signed [DATA_W-1:0] g,
  output logic                     Busy,
  output logic                     Done,
  output logic signed [DATA_W-1:0] j,
  output logic signed [DATA_W-1:0] l
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    FINAL = 3'd4
  } state_t;

  state_t state;

  // Captured operands and intermediate results.
  logic signed [DATA_W-1:0] ra, rb, rc, rd, re, rf, rg;
  logic signed [DATA_W-1:0] h, i, k, m;

  // Inputs and outputs of the shared adder and multiplier.
  logic signed [DATA_W-1:0] add_x, add_y, add_res;
  logic signed [DATA_W-1:0] mul_x, mul_y, mul_res;

  logic accept;

  assign accept = Start && ((state == IDLE) || (state == FINAL));

  // Each state selects the operands of the shared units. In S3 only the
  // adder is needed; the product is already complete in m.
  always_comb begin
    add_x = '0;
    add_y = '0;
    mul_x = '0;
    mul_y = '0;
    case (state)
      S1: begin
        add_x = ra; add_y = rb;
        mul_x = re; mul_y = rf;
      end
      S2: begin
        add_x = h;  add_y = rc;
        mul_x = k;  mul_y = rg;
      end
      S3: begin
        add_x = i;  add_y = rd;
      end
      default: ;
    endcase
  end

  // Results are sized to DATA_W, so both units wrap. The low DATA_W bits of a
  // product do not depend on whether the operands are treated as signed.
  assign add_res = add_x + add_y;
  assign mul_res = mul_x * mul_y;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      ra <= '0; rb <= '0; rc <= '0; rd <= '0;
      re <= '0; rf <= '0; rg <= '0;
      h  <= '0; i  <= '0; k  <= '0; m  <= '0;
      j  <= '0; l  <= '0;
    end else begin
      case (state)
        IDLE:  if (Start) state <= S1;
        S1: begin
          h <= add_res;
          k <= mul_res;
          state <= S2;
        end
        S2: begin
          i <= add_res;
          m <= mul_res;
          state <= S3;
        end
        S3: begin
          j <= add_res;
          l <= m;
          state <= FINAL;
        end
        FINAL: state <= Start ? S1 : IDLE;
        default: state <= IDLE;
      endcase
      // Operands are only captured on acceptance. Later input changes cannot
      // reach the running computation.
      if (accept) begin
        ra <= a; rb <= b; rc <= c; rd <= d;
        re <= e; rf <= f; rg <= g;
      end
    end
  end

  // Moore outputs decoded from the state register. A combinational decode
  // lets an asynchronous reset clear them immediately.
  assign Busy = (state == S1) || (state == S2) || (state == S3);
  assign Done = (state == FINAL);

endmodule

// File: tb/tb_hls_shared_sched.sv
// Purpose : Scoreboard bench for hls_shared_sched at DATA_W=16 and DATA_W=8.
// Latency : Expects results and Done 4 sampled cycles after Start is driven.
// Backpr. : Exercises ignored Start while busy, back-to-back Start and a mid-run async reset.
module tb_hls_shared_sched;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, Start, Start8;
  logic signed [15:0] a, b, c, d, e, f, g, j, l;
  logic signed [7:0]  a8, b8, c8, d8, e8, f8, g8, j8, l8;
  logic Busy, Done, Busy8, Done8;

  hls_shared_sched #(.DATA_W(16)) dut16 (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .Busy(Busy), .Done(Done), .j(j), .l(l)
  );

  hls_shared_sched #(.DATA_W(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Start(Start8),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8),
    .Busy(Busy8), .Done(Done8), .j(j8), .l(l8)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done16   = 0;
  int done8    = 0;
  int d0;

  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int j;
    int l;
    int cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: straight-line wrap-around arithmetic at the instance width.
  function automatic exp_t model16(input logic signed [15:0] av, bv, cv, dv, ev, fv, gv, input int due);
    logic signed [15:0] s, p;
    exp_t x;
    s = av + bv + cv + dv;
    p = ev * fv * gv;
    x.j = int'(s);
    x.l = int'(p);
    x.cyc = due;
    return x;
  endfunction

  function automatic exp_t model8(input logic signed [7:0] av, bv, cv, dv, ev, fv, gv, input int due);
    logic signed [7:0] s, p;
    exp_t x;
    s = av + bv + cv + dv;
    p = ev * fv * gv;
    x.j = int'(s);
    x.l = int'(p);
    x.cyc = due;
    return x;
  endfunction

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge Clk) begin
    exp_t x;
    if (Rst && Done) begin
      done16++;
      chk("done16_pending", (q16.size() > 0) ? 1 : 0, 1);
      if (q16.size() > 0) begin
        x = q16.pop_front();
        chk("j16", int'(j), x.j);
        chk("l16", int'(l), x.l);
        chk("lat16", cyc, x.cyc);
      end
    end
  end

  always @(negedge Clk) begin
    exp_t x;
    if (Rst && Done8) begin
      done8++;
      chk("done8_pending", (q8.size() > 0) ? 1 : 0, 1);
      if (q8.size() > 0) begin
        x = q8.pop_front();
        chk("j8", int'(j8), x.j);
        chk("l8", int'(l8), x.l);
        chk("lat8", cyc, x.cyc);
      end
    end
  end

  // Present an operand set that will be accepted at the coming edge.
  task automatic set16(input logic signed [15:0] av, bv, cv, dv, ev, fv, gv);
    a = av; b = bv; c = cv; d = dv; e = ev; f = fv; g = gv;
    q16.push_back(model16(av, bv, cv, dv, ev, fv, gv, cyc + 4));
  endtask

  task automatic go16(input logic signed [15:0] av, bv, cv, dv, ev, fv, gv);
    set16(av, bv, cv, dv, ev, fv, gv);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic go8(input logic signed [7:0] av, bv, cv, dv, ev, fv, gv);
    a8 = av; b8 = bv; c8 = cv; d8 = dv; e8 = ev; f8 = fv; g8 = gv;
    q8.push_back(model8(av, bv, cv, dv, ev, fv, gv, cyc + 4));
    Start8 = 1'b1;
    @(negedge Clk);
    Start8 = 1'b0;
  endtask

  task automatic scramble16();
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    e = 16'($urandom); f = 16'($urandom); g = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d limit=20000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0; Start = 1'b0; Start8 = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0;
    a8 = '0; b8 = '0; c8 = '0; d8 = '0; e8 = '0; f8 = '0; g8 = '0;

    // Reset state.
    #1;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_j", int'(j), 0);
    chk("rst_l", int'(l), 0);
    chk("rst_busy8", int'(Busy8), 0);
    chk("rst_j8", int'(j8), 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Basic run, with the Busy/Done cycle profile checked.
    go16(16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd2, 16'sd3, 16'sd4);
    chk("basic_busy_t0", int'(Busy), 1);
    chk("basic_done_t0", int'(Done), 0);
    @(negedge Clk);
    chk("basic_busy_t1", int'(Busy), 1);
    @(negedge Clk);
    chk("basic_busy_t2", int'(Busy), 1);
    chk("basic_done_t2", int'(Done), 0);
    @(negedge Clk);
    chk("basic_busy_t3", int'(Busy), 0);
    chk("basic_done_t3", int'(Done), 1);
    @(negedge Clk);
    chk("basic_done_t4", int'(Done), 0);
    chk("basic_busy_t4", int'(Busy), 0);
    repeat (3) @(negedge Clk);
    chk("hold_j", int'(j), 10);
    chk("hold_l", int'(l), 24);

    // Signed operands.
    go16(-16'sd5, 16'sd3, -16'sd1, 16'sd0, -16'sd2, 16'sd7, 16'sd3);
    repeat (4) @(negedge Clk);
    chk("signed_j", int'(j), -3);
    chk("signed_l", int'(l), -42);

    // 16-bit wrap-around.
    go16(16'sd32767, 16'sd1, 16'sd0, 16'sd0, 16'sd256, 16'sd256, 16'sd2);
    repeat (4) @(negedge Clk);
    chk("wrap_j", int'(j), -32768);
    chk("wrap_l", int'(l), 0);

    // 8-bit instance.
    go8(8'sd127, 8'sd1, 8'sd0, 8'sd0, 8'sd16, 8'sd16, 8'sd1);
    repeat (4) @(negedge Clk);
    chk("wrap8_j", int'(j8), -128);
    chk("wrap8_l", int'(l8), 0);
    go8(8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd3, 8'sd5, 8'sd7);
    repeat (5) @(negedge Clk);

    // Start re-pulsed in S2 and operands scrambled while busy.
    d0 = done16;
    go16(16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd3, 16'sd5, 16'sd7);
    scramble16();
    @(negedge Clk);
    scramble16();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    scramble16();
    repeat (6) @(negedge Clk);
    chk("iso_dones", done16 - d0, 1);
    chk("iso_j", int'(j), 100);
    chk("iso_l", int'(l), 105);

    // Back-to-back: Start held for 12 edges, a new set at each FINAL.
    d0 = done16;
    for (int k = 0; k < 12; k++) begin
      if (k >= 1) chk("b2b_busy", int'(Busy), ((k - 1) % 4 != 3) ? 1 : 0);
      if (k % 4 == 0)
        set16(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom));
      else
        scramble16();
      Start = 1'b1;
      @(negedge Clk);
    end
    Start = 1'b0;
    chk("b2b_last_final", int'(Done), 1);
    repeat (6) @(negedge Clk);
    chk("b2b_dones", done16 - d0, 3);

    // Asynchronous reset between edges during S2.
    d0 = done16;
    go16(16'sd7, 16'sd8, 16'sd9, 16'sd10, 16'sd2, 16'sd2, 16'sd2);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("arst_busy", int'(Busy), 0);
    chk("arst_done", int'(Done), 0);
    chk("arst_j", int'(j), 0);
    chk("arst_l", int'(l), 0);
    q16.delete();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (5) @(negedge Clk);
    chk("arst_no_done", done16 - d0, 0);
    go16(16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1);
    repeat (4) @(negedge Clk);
    chk("post_rst_dones", done16 - d0, 1);
    chk("post_rst_j", int'(j), 4);
    chk("post_rst_l", int'(l), 1);

    repeat (2) @(negedge Clk);
    chk("sb16_empty", q16.size(), 0);
    chk("sb8_empty", q8.size(), 0);
    chk("done8_total", done8, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
